// File: rtl/offchip_mem_arbiter_if.sv
// offchip_mem_arbiter_if: icache/dcache request ports and off-chip memory bus of the arbiter
interface offchip_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_done;
  logic              i_err;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_done;
  logic              d_err;
  logic              offchip_mem_read_en;
  logic              offchip_mem_write_en;
  logic [ADDR_W-1:0] offchip_mem_addr;
  logic [LINE_W-1:0] offchip_mem_wdata;
  logic [LINE_W-1:0] offchip_mem_data;
  logic              offchip_mem_ready;
  logic              offchip_mem_read_busy;
  logic              offchip_mem_write_busy;
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, offchip_mem_data, offchip_mem_ready,
    output i_rdata, i_done, i_err, d_rdata, d_done, d_err,
           offchip_mem_read_en, offchip_mem_write_en, offchip_mem_addr, offchip_mem_wdata,
           offchip_mem_read_busy, offchip_mem_write_busy
  );
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, offchip_mem_data, offchip_mem_ready,
    input  i_rdata, i_done, i_err, d_rdata, d_done, d_err,
           offchip_mem_read_en, offchip_mem_write_en, offchip_mem_addr, offchip_mem_wdata,
           offchip_mem_read_busy, offchip_mem_write_busy
  );
endinterface

// File: rtl/offchip_mem_arbiter.sv
// offchip_mem_arbiter: round-robin icache/dcache arbiter for a single off-chip memory port with timeout
module offchip_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  offchip_mem_arbiter_if.master b
);
  typedef enum logic [1:0] {IDLE, I_XFER, D_XFER, RESP} state_t;
  state_t            state;
  logic              last_d;
  logic              we;
  logic              gnt_d;
  logic              dx;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  // dcache wins only when it is alone or icache was served last
  assign gnt_d = b.d_req && (!b.i_req || !last_d);
  assign dx = state == D_XFER;
  assign b.offchip_mem_addr = addr;
  assign b.offchip_mem_wdata = wdata;
  // arbitration FSM with registered handshake, enable and busy outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_d <= 1'b1;
      we <= 1'b0;
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      b.i_rdata <= '0;
      b.d_rdata <= '0;
      b.i_done <= 1'b0;
      b.i_err <= 1'b0;
      b.d_done <= 1'b0;
      b.d_err <= 1'b0;
      b.offchip_mem_read_en <= 1'b0;
      b.offchip_mem_write_en <= 1'b0;
      b.offchip_mem_read_busy <= 1'b0;
      b.offchip_mem_write_busy <= 1'b0;
    end else begin
      b.i_done <= 1'b0;
      b.i_err <= 1'b0;
      b.d_done <= 1'b0;
      b.d_err <= 1'b0;
      case (state)
        IDLE: if (b.i_req || b.d_req) begin
          state <= gnt_d ? D_XFER : I_XFER;
          last_d <= gnt_d;
          we <= gnt_d && b.d_we;
          cnt <= '0;
          addr <= gnt_d ? b.d_addr : b.i_addr;
          wdata <= gnt_d ? b.d_wdata : wdata;
          b.offchip_mem_read_en <= !(gnt_d && b.d_we);
          b.offchip_mem_write_en <= gnt_d && b.d_we;
          b.offchip_mem_read_busy <= !(gnt_d && b.d_we);
          b.offchip_mem_write_busy <= gnt_d && b.d_we;
        end
        I_XFER, D_XFER: if (b.offchip_mem_ready || cnt == 8'(TIMEOUT)) begin
          state <= RESP;
          b.offchip_mem_read_en <= 1'b0;
          b.offchip_mem_write_en <= 1'b0;
          b.i_done <= !dx;
          b.d_done <= dx;
          b.i_err <= !dx && !b.offchip_mem_ready;
          b.d_err <= dx && !b.offchip_mem_ready;
          b.i_rdata <= (b.offchip_mem_ready && !dx) ? b.offchip_mem_data : b.i_rdata;
          b.d_rdata <= (b.offchip_mem_ready && dx && !we) ? b.offchip_mem_data : b.d_rdata;
        end else cnt <= cnt + 8'd1;
        RESP: begin
          state <= IDLE;
          b.offchip_mem_read_busy <= 1'b0;
          b.offchip_mem_write_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_offchip_mem_arbiter.sv
// tb_offchip_mem_arbiter: directed checks of arbitration, latency, timeout and reset abort
module tb_offchip_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 255;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  offchip_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) b ();
  offchip_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    b.i_req = 0; b.i_addr = '0; b.d_req = 0; b.d_we = 0; b.d_addr = '0; b.d_wdata = '0;
    b.offchip_mem_data = '0; b.offchip_mem_ready = 0;
    cyc(2);
    chk("rst_read_en", b.offchip_mem_read_en, 0);
    chk("rst_write_en", b.offchip_mem_write_en, 0);
    chk("rst_addr", b.offchip_mem_addr, 0);
    chk("rst_i_rdata", b.i_rdata, 0);
    chk("rst_busy", {b.offchip_mem_read_busy, b.offchip_mem_write_busy}, 0);
    rst = 0;
    b.i_req = 1; b.i_addr = 32'h100;
    cyc();
    chk("t1_read_en1", b.offchip_mem_read_en, 1);
    chk("t1_addr", b.offchip_mem_addr, 32'h100);
    chk("t1_rbusy", b.offchip_mem_read_busy, 1);
    cyc();
    chk("t1_read_en2", b.offchip_mem_read_en, 1);
    chk("t1_no_done", b.i_done, 0);
    cyc();
    chk("t1_read_en3", b.offchip_mem_read_en, 1);
    b.offchip_mem_ready = 1; b.offchip_mem_data = {16{8'hA5}};
    cyc();
    chk("t1_i_done", b.i_done, 1);
    chk("t1_i_err", b.i_err, 0);
    chk("t1_i_rdata", b.i_rdata, {16{8'hA5}});
    chk("t1_read_en_off", b.offchip_mem_read_en, 0);
    chk("t1_rbusy_resp", b.offchip_mem_read_busy, 1);
    b.i_req = 0; b.offchip_mem_ready = 0;
    cyc();
    chk("t1_done_pulse", b.i_done, 0);
    chk("t1_rbusy_idle", b.offchip_mem_read_busy, 0);
    b.offchip_mem_ready = 1; b.offchip_mem_data = {16{8'h11}};
    cyc();
    chk("idle_ready_ignored", b.i_rdata, {16{8'hA5}});
    chk("idle_ready_no_done", {b.i_done, b.d_done}, 0);
    b.offchip_mem_ready = 0;
    rst = 1;
    cyc();
    rst = 0;
    b.i_req = 1; b.i_addr = 32'h140;
    b.d_req = 1; b.d_we = 1; b.d_addr = 32'h200; b.d_wdata = 128'h1234;
    cyc();
    chk("tie1_read_en", b.offchip_mem_read_en, 1);
    chk("tie1_write_en", b.offchip_mem_write_en, 0);
    chk("tie1_addr", b.offchip_mem_addr, 32'h140);
    b.offchip_mem_ready = 1; b.offchip_mem_data = 128'h77;
    cyc();
    chk("tie1_i_done", {b.i_done, b.d_done}, 2'b10);
    b.offchip_mem_ready = 0; b.i_addr = 32'h180;
    cyc();
    chk("tie1_idle", {b.offchip_mem_read_en, b.offchip_mem_write_en}, 0);
    cyc();
    chk("tie2_write_en", b.offchip_mem_write_en, 1);
    chk("tie2_read_en", b.offchip_mem_read_en, 0);
    chk("tie2_addr", b.offchip_mem_addr, 32'h200);
    chk("tie2_wdata", b.offchip_mem_wdata, 128'h1234);
    chk("tie2_wbusy", b.offchip_mem_write_busy, 1);
    b.d_addr = 32'h999; b.offchip_mem_ready = 1;
    cyc();
    chk("tie2_d_done", {b.d_done, b.d_err, b.i_done}, 3'b100);
    chk("tie2_d_rdata_kept", b.d_rdata, 0);
    chk("tie2_wbusy_resp", b.offchip_mem_write_busy, 1);
    chk("tie2_addr_latched", b.offchip_mem_addr, 32'h200);
    b.d_req = 0; b.offchip_mem_ready = 0;
    cyc(2);
    chk("i_again_addr", b.offchip_mem_addr, 32'h180);
    chk("i_again_read_en", b.offchip_mem_read_en, 1);
    b.offchip_mem_ready = 1; b.offchip_mem_data = 128'h55;
    cyc();
    chk("i_again_rdata", b.i_rdata, 128'h55);
    b.i_req = 0; b.offchip_mem_ready = 0;
    cyc();
    b.d_req = 1; b.d_we = 0; b.d_addr = 32'h300;
    cyc();
    cyc(TO);
    chk("to_exact_read_en", b.offchip_mem_read_en, 1);
    chk("to_exact_no_done", b.d_done, 0);
    b.offchip_mem_ready = 1; b.offchip_mem_data = {16{8'hC3}};
    cyc();
    chk("to_exact_done", {b.d_done, b.d_err}, 2'b10);
    chk("to_exact_rdata", b.d_rdata, {16{8'hC3}});
    b.offchip_mem_ready = 0; b.d_addr = 32'h340;
    cyc(2);
    cyc(TO);
    chk("to_read_en_last", b.offchip_mem_read_en, 1);
    chk("to_no_early_done", b.d_done, 0);
    cyc();
    chk("to_done_err", {b.d_done, b.d_err}, 2'b11);
    chk("to_rdata_kept", b.d_rdata, {16{8'hC3}});
    chk("to_read_en_off", b.offchip_mem_read_en, 0);
    chk("to_rbusy_resp", b.offchip_mem_read_busy, 1);
    b.d_req = 0;
    cyc();
    chk("to_err_pulse", b.d_err, 0);
    b.i_req = 1; b.i_addr = 32'h380; b.offchip_mem_ready = 1;
    cyc(2);
    b.i_req = 0; b.offchip_mem_ready = 0;
    rst = 1;
    cyc();
    rst = 0;
    b.i_req = 1; b.i_addr = 32'h3C0; b.d_req = 1; b.d_addr = 32'h3E0;
    cyc();
    chk("rst_last_served", b.offchip_mem_addr, 32'h3C0);
    b.i_req = 0; b.offchip_mem_ready = 1;
    cyc();
    b.offchip_mem_ready = 0;
    cyc(2);
    chk("rst_mid_d_xfer_state", b.offchip_mem_addr, 32'h3E0);
    rst = 1; b.offchip_mem_ready = 1;
    cyc();
    chk("rst_mid_enables", {b.offchip_mem_read_en, b.offchip_mem_write_en}, 0);
    chk("rst_mid_no_done", {b.d_done, b.d_err}, 0);
    chk("rst_mid_d_rdata", b.d_rdata, 0);
    chk("rst_mid_busy", b.offchip_mem_read_busy, 0);
    rst = 0; b.offchip_mem_ready = 0;
    b.i_req = 1; b.i_addr = 32'h400; b.d_addr = 32'h500;
    cyc();
    chk("rst_mid_tie_addr", b.offchip_mem_addr, 32'h400);
    chk("rst_mid_tie_read_en", b.offchip_mem_read_en, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
